// File: rtl/div8_seq_pkg.sv
// Shared ALU package for the multi-cycle divider: FSM state, iteration count,
// datapath widths and the divide-by-zero quotient constant.
package div8_seq_pkg;

  localparam int unsigned DIV8_W     = 8;
  localparam int unsigned DIV8_R_W   = 9;
  localparam int unsigned DIV8_ITERS = 8;
  localparam int unsigned DIV8_CNT_W = 4;

  localparam logic [DIV8_W-1:0] DIV8_ZERO_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div8_state_e;

endpackage

// File: rtl/div8_seq_if.sv
// Request/result bundle of the DIV/MOD unit.
//   master (sequencer): drives start, dividend, divisor
//   slave  (divider)  : drives busy, done, quotient, remainder, div_zero
interface div8_seq_if;
  import div8_seq_pkg::*;

  logic              start;
  logic [DIV8_W-1:0] dividend;
  logic [DIV8_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DIV8_W-1:0] quotient;
  logic [DIV8_W-1:0] remainder;
  logic              div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div8_seq_sub9.sv
// sub9: 9-bit subtractor diff = a - b built as a ripple of full-adder cells
// fed with ~b and carry-in 1. borrow is the inverted carry-out.
//   a, b   : 9-bit operands
//   diff   : 9-bit difference (mod 2^9)
//   borrow : 1 when a < b
module sub9
  import div8_seq_pkg::*;
(
  input  logic [DIV8_R_W-1:0] a,
  input  logic [DIV8_R_W-1:0] b,
  output logic [DIV8_R_W-1:0] diff,
  output logic                borrow
);

  logic [DIV8_R_W:0]   carry;
  logic [DIV8_R_W-1:0] b_n;

  assign carry[0] = 1'b1;
  assign b_n      = ~b;

  // Full-adder cell per bit, same gate form as the ripple adder.
  for (genvar i = 0; i < DIV8_R_W; i++) begin : g_fa
    assign diff[i]    = a[i] ^ b_n[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_n[i]) | (a[i] & carry[i]) | (b_n[i] & carry[i]);
  end

  assign borrow = ~carry[DIV8_R_W];

endmodule

// File: rtl/div8_seq.sv
// div8_seq: 8-bit unsigned restoring divider, one shift-and-subtract per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : div8_seq_if.slave (start/dividend/divisor in;
//                busy/done/quotient/remainder/div_zero out)
// Optional feature macro: DIV8_EARLY_EXIT_EN -- a zero divisor or a divisor
// larger than the dividend bypasses the iterations and completes in 1 cycle.
module div8_seq
  import div8_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  div8_seq_if.slave bus
);

  div8_state_e             state;
  logic [DIV8_CNT_W-1:0]   iter_cnt;
  logic [DIV8_W-1:0]       q_work;
  logic [DIV8_R_W-1:0]     r_work;
  logic [DIV8_W-1:0]       d_reg;
  logic                    busy_q;
  logic                    done_q;
  logic [DIV8_W-1:0]       quot_q;
  logic [DIV8_W-1:0]       rem_q;
  logic                    div_zero_q;
`ifdef DIV8_EARLY_EXIT_EN
  logic                    early_q;
`endif

  logic [DIV8_R_W-1:0]     r_shift;
  logic [DIV8_R_W-1:0]     trial;
  logic                    borrow;
  logic [DIV8_R_W-1:0]     r_next;
  logic [DIV8_W-1:0]       q_next;
  logic                    last_iter;
  logic                    unused_r_msb;

  // One restoring step: shift the next dividend bit into R, try subtracting D.
  assign r_shift = {r_work[DIV8_W-1:0], q_work[DIV8_W-1]};

  sub9 u_sub9 (
    .a      (r_shift),
    .b      ({1'b0, d_reg}),
    .diff   (trial),
    .borrow (borrow)
  );

  assign r_next    = borrow ? r_shift : trial;
  assign q_next    = {q_work[DIV8_W-2:0], ~borrow};
  assign last_iter = (iter_cnt == DIV8_CNT_W'(DIV8_ITERS - 1));

  // After a restore the remainder is below D, so R[8] only matters inside a step.
  assign unused_r_msb = r_work[DIV8_R_W-1];

  // FSM, iteration counter, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      iter_cnt   <= '0;
      q_work     <= '0;
      r_work     <= '0;
      d_reg      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
`ifdef DIV8_EARLY_EXIT_EN
      early_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            d_reg      <= bus.divisor;
            q_work     <= bus.dividend;
            r_work     <= '0;
            iter_cnt   <= '0;
            div_zero_q <= (bus.divisor == '0);
            state      <= ST_RUN;
`ifdef DIV8_EARLY_EXIT_EN
            // Trivial cases spend a single quiet RUN cycle, busy stays low.
            if ((bus.divisor == '0) || (bus.divisor > bus.dividend)) begin
              early_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              early_q <= 1'b0;
              busy_q  <= 1'b1;
            end
`else
            busy_q     <= 1'b1;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
`ifdef DIV8_EARLY_EXIT_EN
          if (early_q) begin
            // q_work still holds the untouched dividend here.
            early_q <= 1'b0;
            quot_q  <= div_zero_q ? DIV8_ZERO_QUOT : '0;
            rem_q   <= q_work;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= ST_DONE;
          end else begin
`endif
          r_work   <= r_next;
          q_work   <= q_next;
          iter_cnt <= iter_cnt + DIV8_CNT_W'(1);
          if (last_iter) begin
            quot_q <= q_next;
            rem_q  <= r_next[DIV8_W-1:0];
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
`ifdef DIV8_EARLY_EXIT_EN
          end
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = div_zero_q;

endmodule
